// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences each instruction
// and drives every datapath enable, mux select and the ALUOp code.
module multicycle_ctrl #(
   parameter int MEM_LATENCY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [2:0] alu_op,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal_op
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MADR   = 4'd2;
   localparam logic [3:0] S_MRD    = 4'd3;
   localparam logic [3:0] S_MWB    = 4'd4;
   localparam logic [3:0] S_MWR    = 4'd5;
   localparam logic [3:0] S_REX    = 4'd6;
   localparam logic [3:0] S_RWB    = 4'd7;
   localparam logic [3:0] S_BEQ    = 4'd8;
   localparam logic [3:0] S_IEX    = 4'd9;
   localparam logic [3:0] S_IWB    = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

   logic [3:0] r_state;
   logic [3:0] r_cnt;
   logic [5:0] r_op;
   logic [3:0] w_next;
   logic       w_last;
   logic       w_mem;
   logic       w_is_ls;
   logic       w_is_imm;
   logic       w_legal;

   assign w_last   = (r_cnt == LAST);
   assign w_mem    = (r_state == S_FETCH) || (r_state == S_MRD)
                   || (r_state == S_MWR);
   assign w_is_ls  = (opcode == OP_LW) || (opcode == OP_SW);
   assign w_is_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI)
                   || (opcode == OP_ORI) || (opcode == OP_SLTI);
   assign w_legal  = w_is_ls || w_is_imm || (opcode == OP_R)
                   || (opcode == OP_BEQ) || (opcode == OP_J);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (w_last) w_next = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               w_is_ls:            w_next = S_MADR;
               w_is_imm:           w_next = S_IEX;
               (opcode == OP_R):   w_next = S_REX;
               (opcode == OP_BEQ): w_next = S_BEQ;
               (opcode == OP_J):   w_next = S_JUMP;
               default:            w_next = S_FETCH;
            endcase
         end
         S_MADR:   w_next = (r_op == OP_SW) ? S_MWR : S_MRD;
         S_MRD:    if (w_last) w_next = S_MWB;
         S_MWR:    if (w_last) w_next = S_FETCH;
         S_REX:    w_next = S_RWB;
         S_IEX:    w_next = S_IWB;
         default:  w_next = S_FETCH;
      endcase
   end

   // Counter restarts on every state change so it never wraps
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_cnt   <= 4'd0;
         r_op    <= 6'd0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state || !w_mem) r_cnt <= 4'd0;
         else                             r_cnt <= r_cnt + 4'd1;
         if (r_state == S_DECODE) r_op <= opcode;
      end
   end

   assign state = reset ? S_FETCH : r_state;

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      alu_op        = 3'b000;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = w_last;
               pc_write  = w_last;
            end
            S_DECODE: begin
               alu_src_b  = 2'b11;
               illegal_op = !w_legal;
            end
            S_MADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MRD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MWB: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            S_MWR: begin
               mem_write  = 1'b1;
               i_or_d     = 1'b1;
               instr_done = w_last;
            end
            S_REX: begin
               alu_src_a = 1'b1;
               alu_op    = 3'b010;
            end
            S_RWB: begin
               reg_dst    = 1'b1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            S_BEQ: begin
               alu_src_a     = 1'b1;
               alu_op        = 3'b001;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               instr_done    = 1'b1;
            end
            S_IEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               case (r_op)
                  OP_ANDI: alu_op = 3'b011;
                  OP_ORI:  alu_op = 3'b100;
                  OP_SLTI: alu_op = 3'b101;
                  default: alu_op = 3'b000;
               endcase
            end
            S_IWB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            S_JUMP: begin
               pc_write   = 1'b1;
               pc_source  = 2'b10;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
